// File: rtl/fir_axis_out_buf.sv
// fir_axis_out_buf: output FIFO on the FIR Yn stream with a frame-length
// checker on the input side and a delivered-frame counter on the output side.
module fir_axis_out_buf #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [pDATA_WIDTH-1:0]   s_tdata,
    input  logic                     s_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic                     m_tlast,
    input  logic [31:0]              cfg_len,
    input  logic                     err_clr,
    output logic [$clog2(pDEPTH):0]  level,
    output logic [15:0]              frame_cnt,
    output logic                     err_early,
    output logic                     err_late
);

    localparam int AW = $clog2(pDEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LP_FULL    = LW'(pDEPTH);
    localparam logic [LW-1:0] LP_LVL_ONE = LW'(1);
    localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    logic [pDATA_WIDTH:0]   r_mem [0:pDEPTH-1];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [LW-1:0]          r_level;
    logic [15:0]            r_frame_cnt;
    logic                   r_err_early;
    logic                   r_err_late;
    state_t                 r_state;
    logic [31:0]            r_beat_cnt;
    logic [31:0]            r_len_q;

    logic                   w_acc;
    logic                   w_del;
    logic [pDATA_WIDTH:0]   w_rd_entry;
    state_t                 w_state_nxt;
    logic [31:0]            w_beat_nxt;
    logic [31:0]            w_len_nxt;
    logic [31:0]            w_len_eff;
    logic [31:0]            w_pos;
    logic                   w_set_early;
    logic                   w_set_late;

    // Handshakes depend only on registered occupancy, so no s_* to m_* path.
    assign s_tready   = (r_level < LP_FULL);
    assign m_tvalid   = (r_level != '0);
    assign w_acc      = s_tvalid && s_tready;
    assign w_del      = m_tvalid && m_tready;
    assign w_rd_entry = r_mem[r_rptr];
    // The head slot is never overwritten while occupied, so output holds under stall.
    assign m_tdata    = m_tvalid ? w_rd_entry[pDATA_WIDTH-1:0] : '0;
    assign m_tlast    = m_tvalid ? w_rd_entry[pDATA_WIDTH] : 1'b0;
    assign level      = r_level;
    assign frame_cnt  = r_frame_cnt;
    assign err_early  = r_err_early;
    assign err_late   = r_err_late;

    // Storage array: data only, no reset needed.
    always_ff @(posedge axis_clk) begin
        if (w_acc) begin
            r_mem[r_wptr] <= {s_tlast, s_tdata};
        end
    end

    // Pointers, occupancy and delivered-frame counter.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_acc) begin
                r_wptr <= r_wptr + LP_PTR_ONE;
            end
            if (w_del) begin
                r_rptr <= r_rptr + LP_PTR_ONE;
                if (m_tlast) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
            case ({w_acc, w_del})
                2'b10:   r_level <= r_level + LP_LVL_ONE;
                2'b01:   r_level <= r_level - LP_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Frame checker next state: position of the accepted beat against the frame length.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_len_nxt   = r_len_q;
        w_set_early = 1'b0;
        w_set_late  = 1'b0;
        w_len_eff   = (r_state == ST_IDLE) ? cfg_len : r_len_q;
        w_pos       = (r_state == ST_IDLE) ? 32'd1 : (r_beat_cnt + 32'd1);
        if (w_acc) begin
            w_set_early = s_tlast && (w_len_eff != 32'd0) && (w_pos < w_len_eff);
            w_set_late  = !s_tlast && (w_len_eff != 32'd0) && (w_pos == w_len_eff);
            if (s_tlast) begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = 32'd0;
            end else begin
                w_state_nxt = ST_ACTIVE;
                w_beat_nxt  = w_pos;
                if (r_state == ST_IDLE) begin
                    w_len_nxt = cfg_len;
                end
            end
        end
    end

    // Frame checker state and sticky errors; a new error event beats a clear.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_len_q     <= '0;
            r_err_early <= 1'b0;
            r_err_late  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_len_q    <= w_len_nxt;
            if (w_set_early) begin
                r_err_early <= 1'b1;
            end else if (err_clr) begin
                r_err_early <= 1'b0;
            end
            if (w_set_late) begin
                r_err_late <= 1'b1;
            end else if (err_clr) begin
                r_err_late <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_axis_out_buf.sv
// Bench for fir_axis_out_buf: scoreboard queue plus a behavioural frame model.
module tb_fir_axis_out_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic [31:0]   cfg_len = '0;
    logic          err_clr = 1'b0;
    logic [3:0]    level;
    logic [15:0]   frame_cnt;
    logic          err_early;
    logic          err_late;

    fir_axis_out_buf #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .cfg_len    (cfg_len),
        .err_clr    (err_clr),
        .level      (level),
        .frame_cnt  (frame_cnt),
        .err_early  (err_early),
        .err_late   (err_late)
    );

    always #5 axis_clk = ~axis_clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of {last,data}; frames are tracked
    // by beat position within the current frame.
    logic [DW:0]  sb[$];
    longint       m_pos = 0;
    longint       m_len = 0;
    bit           m_early = 0;
    bit           m_late = 0;
    int           m_frames = 0;

    always @(negedge axis_clk) begin
        bit can_acc, se, sl;
        if (!axis_rst_n) begin
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_level", level, 0);
            check("rst_s_tready", s_tready, 1);
            check("rst_m_tdata", m_tdata, 0);
            check("rst_m_tlast", m_tlast, 0);
            check("rst_frame_cnt", frame_cnt, 0);
            check("rst_errs", {err_early, err_late}, 0);
            sb.delete();
            m_pos = 0; m_len = 0; m_early = 0; m_late = 0; m_frames = 0;
        end else begin
            check("level", level, sb.size());
            check("s_tready", s_tready, sb.size() < DEPTH);
            check("m_tvalid", m_tvalid, sb.size() != 0);
            check("frame_cnt", frame_cnt, m_frames);
            check("err_early", err_early, m_early);
            check("err_late", err_late, m_late);
            if (sb.size() != 0) begin
                check("m_data", {m_tlast, m_tdata}, sb[0]);
            end
            can_acc = (sb.size() < DEPTH);
            if (m_tready && sb.size() != 0) begin
                if (sb[0][DW]) m_frames = (m_frames + 1) % 65536;
                void'(sb.pop_front());
            end
            se = 0; sl = 0;
            if (s_tvalid && can_acc) begin
                sb.push_back({s_tlast, s_tdata});
                if (m_pos == 0) m_len = cfg_len;
                m_pos++;
                se = s_tlast && (m_len != 0) && (m_pos < m_len);
                sl = !s_tlast && (m_len != 0) && (m_pos == m_len);
                if (s_tlast) m_pos = 0;
            end
            if (err_clr) begin m_early = 0; m_late = 0; end
            if (se) m_early = 1;
            if (sl) m_late = 1;
        end
    end

    // Downstream ready pattern: 0 always, 1 never, 2 random, 3 manual.
    int rdy_mode = 3;
    initial begin
        forever begin
            @(posedge axis_clk);
            #1;
            case (rdy_mode)
                0: m_tready = 1'b1;
                1: m_tready = 1'b0;
                2: m_tready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l, input int gap_max);
        bit acc;
        int waitc;
        s_tvalid = 1'b0;
        repeat ($urandom_range(0, gap_max)) step();
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        acc = 0;
        waitc = 0;
        while (!acc && waitc < 2000) begin
            @(negedge axis_clk);
            acc = s_tready;
            step();
            waitc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic send_frame(input int n, input int last_at, input int gap_max);
        for (int i = 1; i <= n; i++) begin
            send($urandom, (i == last_at), gap_max);
        end
    endtask

    task automatic drain();
        int c;
        rdy_mode = 0;
        c = 0;
        while ((level != 0 || sb.size() != 0) && c < 5000) begin
            step();
            c++;
        end
        step();
        check("drain_level", level, 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        int fc, len, lastpos;
        axis_rst_n = 1'b0;
        repeat (2) step();
        axis_rst_n = 1'b1;
        step();

        // Nominal frames
        cfg_len = 600;
        rdy_mode = 0;
        send_frame(600, 600, 0);
        drain();
        check("nominal_fc1", frame_cnt, 1);
        send_frame(600, 600, 0);
        send_frame(600, 600, 0);
        drain();
        check("nominal_fc3", frame_cnt, 3);
        check("nominal_errs", {err_early, err_late}, 0);

        // Back-pressure: 9 offered, 8 held
        cfg_len = 9;
        rdy_mode = 1;
        for (int i = 1; i <= 8; i++) send(32'h100 + i, 1'b0, 0);
        s_tvalid = 1'b1;
        s_tdata  = 32'h109;
        s_tlast  = 1'b1;
        @(negedge axis_clk);
        check("bp_level8", level, 8);
        check("bp_s_tready0", s_tready, 0);
        step();
        rdy_mode = 0;
        send(32'h109, 1'b1, 0);
        drain();
        check("bp_fc", frame_cnt, 4);

        // Early tlast
        cfg_len = 11;
        send_frame(5, 5, 1);
        check("early_set", err_early, 1);
        check("early_late0", err_late, 0);
        pulse_clr();
        check("early_clr", err_early, 0);
        drain();

        // Missing tlast
        fc = frame_cnt;
        cfg_len = 4;
        send_frame(6, 6, 0);
        check("late_set", err_late, 1);
        drain();
        check("late_fc_once", frame_cnt, fc + 1);
        pulse_clr();
        check("late_clr", err_late, 0);

        // Simultaneous accept and deliver
        cfg_len = 0;
        rdy_mode = 3;
        m_tready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) send($urandom, 1'b0, 0);
        check("sim_level4", level, 4);
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        m_tready = 1'b1;
        step();
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        check("sim_level_keep", level, 4);
        for (int i = 0; i < 4; i++) send($urandom, 1'b0, 0);
        check("sim_level8", level, 8);
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        m_tready = 1'b1;
        @(negedge axis_clk);
        check("sim_full_ready0", s_tready, 0);
        step();
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        check("sim_level7", level, 7);
        send(32'hABC, 1'b1, 0);
        drain();

        // Reset mid-frame
        cfg_len = 2;
        rdy_mode = 1;
        step();
        send_frame(3, 0, 0);
        check("mr_level3", level, 3);
        check("mr_late_before", err_late, 1);
        axis_rst_n = 1'b0;
        @(negedge axis_clk);
        #1;
        check("mr_m_tvalid", m_tvalid, 0);
        check("mr_level", level, 0);
        check("mr_errs", {err_early, err_late}, 0);
        check("mr_fc", frame_cnt, 0);
        axis_rst_n = 1'b1;
        step();
        cfg_len = 3;
        rdy_mode = 0;
        send_frame(3, 3, 0);
        check("mr_fresh_errs", {err_early, err_late}, 0);
        drain();
        check("mr_fresh_fc", frame_cnt, 1);

        // Randomized frames with random back-pressure on both sides
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 20);
            lastpos = $urandom_range((len > 2) ? len - 2 : 1, len + 2);
            cfg_len = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'(len);
            send_frame(lastpos, lastpos, 3);
            if ($urandom_range(0, 2) == 0) pulse_clr();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_axis_out_buf.md
FIR_AXIS_OUT_BUF -- requirements
Module: fir_axis_out_buf

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 32, stream data width.
REQ-002 SHALL have parameter pDEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-003 SHALL have port axis_clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port axis_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_tvalid  in  1  upstream beat valid (driven by fir sm_tvalid).
REQ-006 SHALL have port s_tready  out  1  upstream ready (drives fir sm_tready).
REQ-007 SHALL have port s_tdata  in  pDATA_WIDTH  upstream Yn sample.
REQ-008 SHALL have port s_tlast  in  1  upstream end-of-frame.
REQ-009 SHALL have port m_tvalid  out  1  downstream beat valid.
REQ-010 SHALL have port m_tready  in  1  downstream ready.
REQ-011 SHALL have port m_tdata  out  pDATA_WIDTH  downstream sample.
REQ-012 SHALL have port m_tlast  out  1  downstream end-of-frame.
REQ-013 SHALL have port cfg_len  in  32  expected beats per frame (same value as the fir 0x10 data_length register); 0 disables checking.
REQ-014 SHALL have port err_clr  in  1  one-cycle clear of sticky errors.
REQ-015 SHALL have port level  out  log2(pDEPTH)+1  current FIFO occupancy.
REQ-016 SHALL have port frame_cnt  out  16  frames delivered downstream.
REQ-017 SHALL have port err_early  out  1  sticky: tlast before cfg_len beats.
REQ-018 SHALL have port err_late  out  1  sticky: no tlast on beat cfg_len.

Function
REQ-019 SHALL accept an input beat iff s_tvalid && s_tready; s_tready = (level < pDEPTH), combinational on registered level only.
REQ-020 SHALL deliver a beat iff m_tvalid && m_tready; m_tvalid = (level != 0).
REQ-021 SHALL store {s_tlast, s_tdata} per entry; m_tdata/m_tlast reproduce input order exactly, no modification.
REQ-022 SHALL present a beat written at edge N on m_tvalid/m_tdata after edge N (first-word latency 1 cycle); no combinational s_* to m_* path.
REQ-023 SHALL hold m_tdata/m_tlast stable while m_tvalid && !m_tready.
REQ-024 SHALL, on simultaneous accept and deliver, keep level unchanged; when full, s_tready=0 even if m_tready=1 that cycle.
REQ-025 SHALL wrap read/write pointers modulo pDEPTH; full/empty from level, not pointer equality.
REQ-026 SHALL run a frame checker with states IDLE and ACTIVE: IDLE->ACTIVE on accepted beat without s_tlast, latching cfg_len into len_q and setting beat_cnt=1; ACTIVE increments beat_cnt per accepted beat; any accepted beat with s_tlast returns to IDLE, beat_cnt=0.
REQ-027 SHALL, for an accepted beat with position p (1-based) and len_q!=0 (cfg_len in IDLE), set err_early if s_tlast && p<len_q, set err_late if !s_tlast && p==len_q.
REQ-028 SHALL ignore cfg_len changes while ACTIVE.
REQ-029 SHALL increment frame_cnt on each delivered beat with m_tlast=1, wrapping 0xFFFF->0x0000.
REQ-030 SHALL clear err_early/err_late on err_clr; a set event in the same cycle wins.
REQ-031 SHALL never drop or duplicate a beat, including under back-pressure on both sides.

Reset
REQ-032 SHALL, while axis_rst_n=0, force: pointers 0, level 0, m_tvalid 0, m_tdata 0, m_tlast 0, s_tready 1, frame_cnt 0, err_early 0, err_late 0, checker IDLE, beat_cnt 0.
REQ-033 SHALL discard all buffered beats on reset asserted mid-frame; first accepted beat after release starts a new frame.

Verification
REQ-034 SHALL cover nominal frame: cfg_len=600, 600 beats, s_tlast on beat 600, m_tready=1 -> 600 outputs in order, m_tlast only on beat 600, frame_cnt=1, no errors, three back-to-back frames -> frame_cnt=3.
REQ-035 SHALL cover back-pressure: m_tready=0, offer 9 beats -> 8 accepted, level=8, s_tready=0; then m_tready=1 -> beats 1..9 in order, level returns 0.
REQ-036 SHALL cover early tlast: cfg_len=11, s_tlast on beat 5 -> err_early=1 after that edge, err_late=0; err_clr pulse -> err_early=0.
REQ-037 SHALL cover missing tlast: cfg_len=4, beat 4 without s_tlast -> err_late=1; s_tlast on beat 6 ends frame, frame_cnt increments once on drain.
REQ-038 SHALL cover simultaneous ops: level=4 with accept and deliver same cycle -> level 4; level=8 with s_tvalid=1, m_tready=1 -> s_tready=0, level 7 next cycle.
REQ-039 SHALL cover reset mid-frame: 3 beats buffered, axis_rst_n low for one half-cycle -> m_tvalid=0, level=0, errors 0, frame_cnt 0; next frame checks against fresh cfg_len.
